// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM state encoding and header constants for the program loader
package program_loader_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: assembles four accepted bytes little-endian into a 32-bit word
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic        load_i,
  output logic [31:0] word_o,
  output logic        last_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  // shifting in from the top leaves the first byte in bits 7:0 after four loads
  always_comb begin
    idx_d  = load_i ? idx_q + 2'd1 : idx_q;
    word_d = load_i ? {data_i, word_q[31:8]} : word_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end
  assign word_o = word_q;
  assign last_o = load_i && idx_q == 2'd3;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed byte image into instruction memory, holding the core meanwhile.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        inByte,
  input  logic              inValid,
  output logic              inReady,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memData,
  input  logic              memReady,
  output logic              coreHold,
  output logic              done,
  output logic              error
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t AFTER = CHECK;
  logic [7:0] csum_q;
`else
  localparam state_t AFTER = DONE;
`endif
  state_t            state_q, state_d;
  logic              run_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              take, word_last;
  // run_q keeps inReady low until the first edge after reset release
  assign inReady = run_q && (state_q == HDR0 || state_q == HDR1 || state_q == DATA || state_q == CHECK);
  assign take    = inValid && inReady;
  byte_packer u_packer (
    .clock (clock),
    .reset (reset),
    .data_i(inByte),
    .load_i(take && state_q == DATA),
    .word_o(memData),
    .last_o(word_last)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      HDR0: if (take) begin
        cnt_d[7:0] = inByte;
        state_d    = HDR1;
      end
      HDR1: if (take) begin
        cnt_d[15:8] = inByte;
        state_d     = {inByte, cnt_q[7:0]} == 16'd0 ? AFTER : DATA;
      end
      DATA: state_d = word_last ? WRITE : DATA;
      WRITE: if (memReady) begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'd1;
        state_d = cnt_q == 16'd1 ? AFTER : DATA;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: if (take) state_d = inByte == csum_q ? DONE : ERROR;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HDR0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) csum_q <= '0;
    else if (take && state_q == DATA) csum_q <= csum_q ^ inByte;
  end
  assign error = state_q == ERROR;
`else
  assign error = 1'b0;
`endif
  assign memWrite = state_q == WRITE;
  assign memAddr  = addr_q;
  assign coreHold = state_q != DONE;
  assign done     = state_q == DONE;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader (ADDR_W=2 to exercise address wrap)
module tb_program_loader;
  localparam int AW = 2;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    inByte = '0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic          memWrite;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic          memReady = 1'b1;
  logic          coreHold;
  logic          done;
  logic          error;
  int            checks = 0;
  int            fails = 0;
  int            nw = 0;
  logic [AW-1:0] wa [64];
  logic [31:0]   wd [64];

  program_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .inByte(inByte), .inValid(inValid), .inReady(inReady),
    .memWrite(memWrite), .memAddr(memAddr), .memData(memData), .memReady(memReady),
    .coreHold(coreHold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (memWrite && memReady && nw < 64) begin
    wa[nw] <= memAddr;
    wd[nw] <= memData;
    nw <= nw + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inReady"}, 32'(inReady), 0);
    chk({tag, "_memWrite"}, 32'(memWrite), 0);
    chk({tag, "_memAddr"}, 32'(memAddr), 0);
    chk({tag, "_memData"}, memData, 0);
    chk({tag, "_coreHold"}, 32'(coreHold), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    inByte = b;
    inValid = 1'b1;
    @(negedge clock);
    while (!inReady && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!inReady) chk("send_timeout", 32'(inReady), 1);
    @(posedge clock);
    #1 inValid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    inValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic finish_stream(input logic [7:0] csum);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(csum);
`else
    if (csum === 8'hxx) $display("unused");
`endif
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int base;
    #1;
    chk_reset_vals("rst");
    do_reset();
    @(posedge clock) #1;
    chk("first_edge_inReady", 32'(inReady), 1);

    base = nw;
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h00); send(8'h00);
    send(8'h93); send(8'h05); send(8'h10); send(8'h00);
    finish_stream(8'h90);
    chk("two_words_count", 32'(nw - base), 2);
    chk("w0_addr", 32'(wa[base]), 0);
    chk("w0_data", wd[base], 32'h00000513);
    chk("w1_addr", 32'(wa[base+1]), 1);
    chk("w1_data", wd[base+1], 32'h00100593);
    chk("two_words_done", 32'(done), 1);
    chk("two_words_coreHold", 32'(coreHold), 0);
    chk("done_inReady", 32'(inReady), 0);

    do_reset();
    base = nw;
    send(8'h00); send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    @(negedge clock);
    chk("empty_done", 32'(done), 1);
    chk("empty_no_write", 32'(nw - base), 0);

    do_reset();
    base = nw;
    memReady = 1'b0;
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD);
    send(8'hDE);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("stall_memWrite", 32'(memWrite), 1);
      chk("stall_memAddr", 32'(memAddr), 0);
      chk("stall_memData", memData, 32'hDEADBEEF);
      chk("stall_inReady", 32'(inReady), 0);
      if (i == 5) memReady = 1'b1;
    end
    @(posedge clock) #1;
    chk("stall_released", 32'(memWrite), 0);
    chk("stall_one_write", 32'(nw - base), 1);
    finish_stream(8'h22);
    chk("stall_done", 32'(done), 1);

    do_reset();
    base = nw;
    send(8'h05); send(8'h00);
    for (int k = 0; k < 20; k++) send(8'(k));
    finish_stream(8'h00);
    chk("wrap_count", 32'(nw - base), 5);
    chk("wrap_a0", 32'(wa[base]), 0);
    chk("wrap_a1", 32'(wa[base+1]), 1);
    chk("wrap_a2", 32'(wa[base+2]), 2);
    chk("wrap_a3", 32'(wa[base+3]), 3);
    chk("wrap_a4", 32'(wa[base+4]), 0);
    chk("wrap_d0", wd[base], 32'h03020100);
    chk("wrap_d4", wd[base+4], 32'h13121110);
    chk("wrap_done", 32'(done), 1);

    do_reset();
    send(8'h03); send(8'h00);
    for (int k = 0; k < 6; k++) send(8'h40 + 8'(k));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clock);
    reset = 1'b1;
    base = nw;
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    finish_stream(8'h00);
    chk("reload_count", 32'(nw - base), 1);
    chk("reload_addr", 32'(wa[base]), 0);
    chk("reload_data", wd[base], 32'hDDCCBBAA);
    chk("reload_done", 32'(done), 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_reset();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    finish_stream(8'h0F);
    chk("csum_ok_done", 32'(done), 1);
    chk("csum_ok_error", 32'(error), 0);
    do_reset();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    finish_stream(8'h0E);
    chk("csum_bad_error", 32'(error), 1);
    chk("csum_bad_coreHold", 32'(coreHold), 1);
    chk("csum_bad_done", 32'(done), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
